// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Default datapath width comes from the XLEN macro (64 when undefined).
`ifndef XLEN
`define XLEN 64
`endif

package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int W_ITERS  = 32;
    localparam int MAX_XLEN = 64;

    function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(MAX_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/int_muldiv_step.sv
// File kept for module name compatibility: one restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvsr,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, i_dvsr};
    // When w_ge holds the difference is below the divisor, so XLEN bits suffice.
    assign w_sub   = w_shift[XLEN-1:0] - i_dvsr;

    assign o_rem = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/int_muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit with W-mode ops.
// Define MULDIV_FAST_MUL_EN for single-cycle registered multiplies.
module int_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = `XLEN,
    parameter bit W_SUPPORT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [2:0]      i_in_op,
    input  logic            i_in_is_w,
    input  logic [XLEN-1:0] i_in_a,
    input  logic [XLEN-1:0] i_in_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_result
);

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v,
                                              input logic s);
        logic [MAX_XLEN-1:0] t;
        t = s ? sext32(v) : {32'h0, v};
        return t[XLEN-1:0];
    endfunction

    muldiv_state_t r_state, w_state_nxt;
    muldiv_op_t    w_op;

    logic            w_w, w_is_div, w_is_rem, w_sdiv, w_zext;
    logic            w_a_sen, w_b_sen, w_a_neg, w_b_neg;
    logic            w_div0, w_ovf, w_illegal, w_special, w_fast;
    logic            w_accept, w_last;
    logic [XLEN-1:0] w_a_n, w_b_n, w_mag_a, w_mag_b, w_min;
    logic [XLEN-1:0] w_spec_raw, w_spec_res, w_fast_res;

    logic [CW-1:0]     r_cnt;
    logic              r_is_w, r_is_div, r_is_rem, r_hi;
    logic              r_neg, r_rneg, r_direct;
    logic [2*XLEN-1:0] r_acc, r_mcand;
    logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvsr, r_result;

    logic [XLEN-1:0]   w_step_rem, w_step_quo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_raw, w_final;

    always_comb begin
        w_w      = W_SUPPORT && i_in_is_w;
        w_op     = muldiv_op_t'(i_in_op);
        w_is_div = i_in_op[2];
        w_is_rem = i_in_op[2] & i_in_op[1];
        w_sdiv   = i_in_op[2] & ~i_in_op[0];
        w_zext   = w_w & w_is_div & i_in_op[0];
        w_a_sen  = 1'b0;
        w_b_sen  = 1'b0;
        unique case (w_op)
            OP_MUL, OP_MULH,
            OP_DIV, OP_REM:    begin w_a_sen = 1'b1; w_b_sen = 1'b1; end
            OP_MULHSU:         begin w_a_sen = 1'b1; w_b_sen = 1'b0; end
            OP_MULHU, OP_DIVU,
            OP_REMU:           begin w_a_sen = 1'b0; w_b_sen = 1'b0; end
        endcase
        w_a_n   = w_w ? ext32(i_in_a[31:0], ~w_zext) : i_in_a;
        w_b_n   = w_w ? ext32(i_in_b[31:0], ~w_zext) : i_in_b;
        w_a_neg = w_a_sen & w_a_n[XLEN-1];
        w_b_neg = w_b_sen & w_b_n[XLEN-1];
        w_mag_a = w_a_neg ? -w_a_n : w_a_n;
        w_mag_b = w_b_neg ? -w_b_n : w_b_n;
        w_min   = w_w ? ext32(32'h8000_0000, 1'b1)
                      : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        w_div0    = w_is_div && (w_b_n == '0);
        w_ovf     = w_sdiv && (w_a_n == w_min) && (w_b_n == '1);
        w_illegal = w_w && !w_is_div && (i_in_op[1:0] != 2'b00);
        w_special = w_div0 | w_ovf | w_illegal;
        w_spec_raw = '0;
        unique case (1'b1)
            w_illegal: w_spec_raw = '0;
            w_div0:    w_spec_raw = w_is_rem ? w_a_n : '1;
            w_ovf:     w_spec_raw = w_is_rem ? '0 : w_a_n;
            default:   w_spec_raw = '0;
        endcase
        w_spec_res = w_w ? ext32(w_spec_raw[31:0], 1'b1) : w_spec_raw;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod_u, w_fprod;
    logic [XLEN-1:0]   w_fast_raw;

    always_comb begin
        w_fast     = !w_is_div;
        w_fprod_u  = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
        w_fprod    = (w_a_neg ^ w_b_neg) ? -w_fprod_u : w_fprod_u;
        w_fast_raw = (i_in_op[1:0] != 2'b00) ? w_fprod[2*XLEN-1:XLEN]
                                             : w_fprod[XLEN-1:0];
        w_fast_res = w_w ? ext32(w_fast_raw[31:0], 1'b1) : w_fast_raw;
    end
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    muldiv_div_step #(.XLEN(XLEN)) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_step_rem),
        .o_quo  (w_step_quo)
    );

    // Sign fix-up and W narrowing of the finished iterative result.
    always_comb begin
        w_prod  = r_neg ? -r_acc : r_acc;
        w_quo   = r_neg ? -r_quo : r_quo;
        w_rem   = r_rneg ? -r_rem : r_rem;
        if (r_is_div)
            w_raw = r_is_rem ? w_rem : w_quo;
        else
            w_raw = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        w_final = r_is_w ? ext32(w_raw[31:0], 1'b1) : w_raw;
    end

    assign w_accept = (r_state == IDLE) && i_in_valid && !i_flush;
    assign w_last   = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (i_in_valid)
                          w_state_nxt = (w_special || w_fast) ? DONE : BUSY;
                BUSY: if (w_last)
                          w_state_nxt = DONE;
                DONE: if (i_out_ready)
                          w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_result <= '0;
            r_direct <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt    <= w_w ? CW'(W_ITERS - 1) : CW'(XLEN - 1);
            r_is_w   <= w_w;
            r_is_div <= w_is_div;
            r_is_rem <= w_is_rem;
            r_hi     <= (i_in_op[1:0] != 2'b00);
            r_neg    <= w_a_neg ^ w_b_neg;
            r_rneg   <= w_a_neg;
            r_direct <= w_special | w_fast;
            r_result <= w_special ? w_spec_res : w_fast_res;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_rem    <= '0;
            // W dividends are left-aligned so 32 steps consume all their bits.
            r_quo    <= w_w ? (w_mag_a << (XLEN - 32)) : w_mag_a;
            r_dvsr   <= w_mag_b;
        end else if (r_state == BUSY) begin
            if (!w_last)
                r_cnt <= r_cnt - CW'(1);
            if (r_is_div) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
            end else begin
                if (r_mplier[0])
                    r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end else if (r_state == DONE && i_out_ready) begin
            r_result <= '0;
        end
    end

    assign o_in_ready   = (r_state == IDLE);
    assign o_out_valid  = (r_state == DONE);
    assign o_out_result = (r_state != DONE) ? '0
                        : (r_direct ? r_result : w_final);

    a_no_illegal_w: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_accept && w_illegal));

endmodule

// File: tb/tb_int_muldiv_unit.sv
// Directed self-checking bench for int_muldiv_unit (XLEN=64).
module tb_int_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int LM64 = 1;
    localparam int LM32 = 1;
`else
    localparam int LM64 = 65;
    localparam int LM32 = 33;
`endif
    localparam int LD64 = 65;
    localparam int LD32 = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic        in_is_w = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;

    int total = 0;
    int bad = 0;

    logic [63:0] res;
    logic [63:0] held;
    int          lat;
    logic        seen;

    int_muldiv_unit #(.XLEN(64), .W_SUPPORT(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_op      (in_op),
        .i_in_is_w    (in_is_w),
        .i_in_a       (in_a),
        .i_in_b       (in_b),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_result (out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_op = op; in_is_w = w; in_a = a; in_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [63:0] r, output int l);
        l = 1;
        while (!out_valid && l < 300) begin
            @(posedge clk);
            #1;
            l++;
        end
        r = out_result;
    endtask

    task automatic consume;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int exp_lat);
        issue(op, w, a, b);
        wait_done(res, lat);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        consume();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", out_result, 64'd0);
        rst = 1'b0;

        run("mulw", 3'd0, 1'b1, 64'h11223344AADDEEFF, 64'd2,
            64'h0000000055BBDDFE, LM32);
        chk("post_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_out_valid", {63'd0, out_valid}, 64'd0);
        run("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, LM64);
        run("mul", 3'd0, 1'b0, '1, '1, 64'h1, LM64);
        run("mulh", 3'd1, 1'b0, '1, '1, 64'h0, LM64);
        run("mulhsu", 3'd2, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, LM64);
        run("div", 3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, LD64);
        run("rem", 3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF, LD64);
        run("remu", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, LD64);
        run("div0", 3'd4, 1'b0, 64'd7, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
        run("rem0", 3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1);
        run("remuw0", 3'd7, 1'b1, 64'h1234567887654321,
            64'hFFFFFFFF00000000, 64'hFFFFFFFF87654321, 1);
        run("divw_ovf", 3'd4, 1'b1, 64'hAAAAAAAA80000000,
            64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1);
        run("remw_ovf", 3'd6, 1'b1, 64'hAAAAAAAA80000000,
            64'h00000000FFFFFFFF, 64'h0, 1);
        run("divw_neg", 3'd4, 1'b1, 64'h00000000FFFFFFF7, 64'd4,
            64'hFFFFFFFFFFFFFFFE, LD32);

        issue(3'd5, 1'b1, 64'd100, 64'd7);
        wait_done(held, lat);
        chk("hold_res", held, 64'd14);
        chk("hold_lat", 64'(lat), 64'(LD32));
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_stable", out_result, held);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
        end
        consume();
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);

        issue(3'd5, 1'b0, 64'd1000, 64'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_result", out_result, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("flush_no_valid", {63'd0, seen}, 64'd0);
        run("remuw", 3'd7, 1'b1, 64'd9, 64'd4, 64'd1, LD32);

        issue(3'd4, 1'b0, -64'sd100, 64'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        run("remw", 3'd6, 1'b1, 64'h00000000FFFFFFF7, 64'd4,
            64'hFFFFFFFFFFFFFFFF, LD32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
